// File: rtl/bus_if.sv
// bus_if: CPU-side valid/ready request bus between the core and the bridge
interface bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  lane;
  logic        wr;
  logic        valid;
  logic [31:0] rdata;
  logic        ready;
  modport master (output addr, wdata, lane, wr, valid, input rdata, ready);
  modport slave  (input addr, wdata, lane, wr, valid, output rdata, ready);
endinterface

// File: rtl/bus_bridge.sv
// bus_bridge: valid/ready bridge to byte-enabled SRAM, an I/O page and an unmapped-access error path
module bus_bridge #(
  parameter int          SRAM_AW     = 12,
  parameter int          OUT_W       = 16,
  parameter logic [31:0] OUT_RESET   = '0,
  parameter int          IN_W        = 8,
  parameter int          WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_if.slave             io_bus,
  output logic [OUT_W-1:0] o_out_port,
  input  logic [IN_W-1:0]  i_in_port,
  output logic             o_bus_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  typedef enum logic [1:0] {RG_SRAM, RG_IO, RG_BAD} region_t;
  state_t             r_state, w_next;
  region_t            r_region, w_region;
  logic [SRAM_AW-1:0] r_idx;
  logic [1:0]         r_sel;
  logic [31:0]        r_wdata, r_timer, r_rdata, r_q, w_mask, w_io, w_out_new, w_timer_new;
  logic [3:0]         r_lane, r_cnt;
  logic               r_wr, r_ready, r_err, r_bus_err;
  logic [OUT_W-1:0]   r_out;
  logic [IN_W-1:0]    r_s1, r_s2;
  logic [31:0]        r_mem [2**SRAM_AW];
  logic               w_last, w_commit, w_to_done, w_unused;
  assign w_unused    = ^io_bus.addr;
  assign w_region    = io_bus.addr[31:20] == 12'h000 ? RG_SRAM :
                       io_bus.addr[31:20] == 12'h100 ? RG_IO : RG_BAD;
  assign w_mask      = {{8{r_lane[3]}}, {8{r_lane[2]}}, {8{r_lane[1]}}, {8{r_lane[0]}}};
  assign w_out_new   = (r_wdata & w_mask) | (32'(r_out) & ~w_mask);
  assign w_timer_new = (r_wdata & w_mask) | (r_timer & ~w_mask);
  assign w_io        = r_region != RG_IO ? 32'd0 :
                       r_sel == 2'd0 ? 32'(r_out) :
                       r_sel == 2'd1 ? 32'(r_s2) :
                       r_sel == 2'd2 ? r_timer : {31'd0, r_err};
  assign w_last      = r_cnt == 4'(WAIT_STATES - 1);
  assign w_commit    = r_state == ACCESS && r_wr;
  assign w_to_done   = w_next == DONE && r_state != DONE;
  assign io_bus.rdata = r_rdata;
  assign io_bus.ready = r_ready;
  assign o_out_port   = r_out;
  assign o_bus_err    = r_bus_err;
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Next-state: accept in IDLE, one commit cycle, optional wait count, hold DONE while valid
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = io_bus.valid ? ACCESS : IDLE;
      ACCESS:  w_next = WAIT_STATES == 0 ? DONE : WAIT;
      WAIT:    w_next = w_last ? DONE : WAIT;
      DONE:    w_next = io_bus.valid ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // SRAM: byte-lane write at commit; registered read of the latched word feeds rdata in DONE
  always_ff @(posedge clk) begin
    if (w_commit && r_region == RG_SRAM)
      for (int i = 0; i < 4; i++)
        if (r_lane[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
    r_q <= r_mem[r_idx];
  end
  // Request latch, I/O registers, read data capture and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_sel     <= '0;
      r_region  <= RG_BAD;
      r_wdata   <= '0;
      r_lane    <= '0;
      r_wr      <= 1'b0;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_bus_err <= 1'b0;
      r_err     <= 1'b0;
      r_out     <= OUT_RESET[OUT_W-1:0];
      r_s1      <= '0;
      r_s2      <= '0;
    end else begin
      r_s1 <= i_in_port;
      r_s2 <= r_s1;
      if (r_state == IDLE && io_bus.valid) begin
        r_idx    <= io_bus.addr[SRAM_AW+1:2];
        r_sel    <= io_bus.addr[3:2];
        r_region <= w_region;
        r_wdata  <= io_bus.wdata;
        r_lane   <= io_bus.lane;
        r_wr     <= io_bus.wr;
      end
      r_cnt   <= r_state == WAIT ? r_cnt + 4'd1 : 4'd0;
      r_timer <= w_commit && r_region == RG_IO && r_sel == 2'd2 ? w_timer_new : r_timer + 32'd1;
      if (w_commit && r_region == RG_IO && r_sel == 2'd0) r_out <= w_out_new[OUT_W-1:0];
      if (w_commit && r_region == RG_IO && r_sel == 2'd3 && r_lane[0] && r_wdata[0]) r_err <= 1'b0;
      if (r_state == ACCESS && r_region == RG_BAD) r_err <= 1'b1;
      if (!r_wr && w_to_done && r_region != RG_SRAM) r_rdata <= w_io;
      if (!r_wr && r_state == DONE && !r_ready && r_region == RG_SRAM) r_rdata <= r_q;
      r_ready   <= r_state == DONE && io_bus.valid;
      r_bus_err <= r_state == DONE && !r_ready && io_bus.valid && r_region == RG_BAD;
    end
  end
endmodule
